// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation
// encodings, controller states, default width and the divide-by-zero
// quotient.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    // Quotient reported when the divisor is zero, whatever the signedness.
    localparam logic [MDU_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mdu_state_e;

    // Signed variants treat both operands as two's complement.
    function automatic logic op_is_signed(input mdu_op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on magnitudes: shift {rem, quot} left by one,
// subtract the divisor from the partial remainder if it fits and shift the
// resulting quotient bit in at the bottom.
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH:0] rem_sh;
    logic           fits;

    // Partial remainder keeps a carry bit so the compare is exact even when
    // the shifted remainder exceeds WIDTH bits; the difference always fits.
    always_comb begin
        rem_sh   = {rem_in, quot_in[WIDTH-1]};
        fits     = (rem_sh >= {1'b0, divisor});
        rem_out  = fits ? (rem_sh[WIDTH-1:0] - divisor) : rem_sh[WIDTH-1:0];
        quot_out = {quot_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes at start, RUN performs one shift-add or
// restoring-divide step per cycle, FIN applies the sign correction and
// writes HI/LO. Optional macro MDU_FAST_MULT_EN makes MULT/MULTU compute
// the product in one cycle and skip RUN.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH       = MDU_WIDTH,
    parameter int ITER_CYCLES = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(ITER_CYCLES);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;    // product high half / remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;    // multiplier bits / quotient
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic [WIDTH-1:0]   a_q, a_d;              // raw dividend for divide-by-zero
    logic               is_div_q, is_div_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;

    mdu_op_e            op_in;
    logic               in_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_mag;
    logic [WIDTH-1:0]   div_rem_next, div_quot_next;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in   (acc_hi_q),
        .quot_in  (acc_lo_q),
        .divisor  (b_mag_q),
        .rem_out  (div_rem_next),
        .quot_out (div_quot_next)
    );

    // Operand magnitudes and the shift-add datapath for one multiply step.
    always_comb begin
        op_in     = mdu_op_e'(op);
        in_signed = op_is_signed(op_in);
        a_neg     = in_signed & a[WIDTH-1];
        b_neg     = in_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_mag_q} : '0);
        prod_mag  = {acc_hi_q, acc_lo_q};
    end

`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
`endif

    // Controller next-state, datapath steps, HI/LO writes and sign correction.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        b_mag_d    = b_mag_q;
        a_d        = a_q;
        is_div_d   = is_div_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        div0_d     = div0_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // A start in the same cycle as an MTHI/MTLO drops the write.
                    a_d        = a;
                    b_mag_d    = b_mag;
                    is_div_d   = op_is_div(op_in);
                    neg_quot_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div0_d     = op_is_div(op_in) && (b == '0);
                    acc_hi_d   = '0;
                    acc_lo_d   = a_mag;
                    counter_d  = CNT_W'(ITER_CYCLES - 1);
                    state_d    = RUN;
`ifdef MDU_FAST_MULT_EN
                    if (!op_is_div(op_in)) begin
                        {acc_hi_d, acc_lo_d} = fast_prod;
                        state_d              = FIN;
                    end
`endif
                end else begin
                    if (wr_hi) hi_d = wr_data;
                    if (wr_lo) lo_d = wr_data;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_hi_d = div_rem_next;
                    acc_lo_d = div_quot_next;
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (counter_q == '0) begin
                    state_d = FIN;
                end else begin
                    counter_d = counter_q - CNT_W'(1);
                end
            end
            FIN: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_quot_q ? -prod_mag : prod_mag;
                end else if (div0_q) begin
                    hi_d = a_q;
                    lo_d = WIDTH'(DIV0_QUOTIENT);
                end else begin
                    hi_d = neg_rem_q  ? -acc_hi_q : acc_hi_q;
                    lo_d = neg_quot_q ? -acc_lo_q : acc_lo_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            b_mag_q    <= '0;
            a_q        <= '0;
            is_div_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            b_mag_q    <= b_mag_d;
            a_q        <= a_d;
            is_div_q   <= is_div_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            div0_q     <= div0_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
